// File: rtl/cmp2_sweep_checker_if.sv
// Purpose : bundles the checker's control/result and comparator-drive signals.
// Latency : n/a (wiring only).
// Backpressure: none; start is a level request, done is a one-cycle pulse.
// Ports: master = checker side (drives operands and results), slave = environment.
interface cmp2_sweep_checker_if;
  logic       start;
  logic [1:0] a_out;
  logic [1:0] b_out;
  logic       aeqb_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic       fail_valid;
  logic [3:0] first_fail;

  modport master (
    input  start, aeqb_in,
    output a_out, b_out, busy, done, pass, err_cnt, fail_valid, first_fail
  );

  modport slave (
    output start, aeqb_in,
    input  a_out, b_out, busy, done, pass, err_cnt, fail_valid, first_fail
  );
endinterface

// File: rtl/cmp2_sweep_checker.sv
// Purpose : sweeps all 16 {a,b} pairs into a 2-bit equality comparator and scores its answers.
// Latency : done pulses 16*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge.
// Backpressure: none; start is only looked at in IDLE, ignored while a sweep runs.
// Ports: clk, reset_n (sync, active-low); bus (master) carries start, a_out/b_out,
//        aeqb_in, busy, done, pass, err_cnt, fail_valid, first_fail.
module cmp2_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cmp2_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  // With no settle time each pair goes straight to its sampling cycle.
  localparam state_t AFTER_LOAD = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic       fail_valid_q, fail_valid_d;
  logic [3:0] first_fail_q, first_fail_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  logic expected_eq;
  logic mismatch;

  assign expected_eq = (idx_q[3:2] == idx_q[1:0]);
  assign mismatch    = (bus.aeqb_in != expected_eq);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d        = 4'd0;
          err_cnt_d    = 5'd0;
          fail_valid_d = 1'b0;
          first_fail_d = 4'd0;
          pass_d       = 1'b0;
          cnt_d        = SETTLE_LOAD;
          state_d      = AFTER_LOAD;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          // Saturating guard; a full sweep tops out at 16 anyway.
          if (err_cnt_q != 5'd31) begin
            err_cnt_d = err_cnt_q + 5'd1;
          end
          if (!fail_valid_q) begin
            first_fail_d = idx_q;
            fail_valid_d = 1'b1;
          end
        end
        if (idx_q != 4'd15) begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = AFTER_LOAD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        // err_cnt_q already includes the idx=15 result here, so the
        // verdict and the done pulse land together on the next edge.
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == 5'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SETTLE) || (state_d == CHECK);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      cnt_q        <= 4'd0;
      err_cnt_q    <= 5'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 4'd0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // Operands come straight from the index flop, so they hold in IDLE.
  assign bus.a_out      = idx_q[3:2];
  assign bus.b_out      = idx_q[1:0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_cmp2_sweep_checker.sv
module tb_cmp2_sweep_checker;

  typedef struct {
    int err;
    int ff;
    int fv;
    int ps;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst2_n;
  logic rst0_n;
  int   mode;   // 0 = correct comparator, 1 = stuck at 0, 2 = stuck at 1
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  int   idxq[$];

  cmp2_sweep_checker_if i2 ();
  cmp2_sweep_checker_if i0 ();

  assign i2.aeqb_in = (mode == 0) ? (i2.a_out == i2.b_out) : (mode == 2);
  assign i0.aeqb_in = (i0.a_out == i0.b_out);

  cmp2_sweep_checker #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .reset_n(rst2_n), .bus(i2)
  );
  cmp2_sweep_checker #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(rst0_n), .bus(i0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference outcome of one sweep given the comparator behaviour.
  function automatic exp_t model(input int md, input int lat);
    exp_t e;
    logic [3:0] ix;
    logic ref_eq, dut_eq;
    e.err = 0; e.ff = 0; e.lat = lat;
    for (int i = 0; i < 16; i++) begin
      ix = i[3:0];
      ref_eq = (ix[3:2] == ix[1:0]);
      dut_eq = (md == 0) ? ref_eq : (md == 2);
      if (dut_eq != ref_eq) begin
        if (e.err == 0) e.ff = i;
        e.err++;
      end
    end
    e.fv = (e.err != 0) ? 1 : 0;
    e.ps = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic finish2(input bit mid_start);
    int k;
    bit got;
    exp_t e;
    k = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      if (mid_start) i2.start = (k == 10);
      tick;
      k++;
      if (i2.done === 1'b1) got = 1'b1;
    end
    e = sb.pop_front();
    chk("done_seen", got, 1);
    chk("latency", k, e.lat);
    chk("err_cnt", i2.err_cnt, e.err);
    chk("fail_valid", i2.fail_valid, e.fv);
    if (e.fv != 0) chk("first_fail", i2.first_fail, e.ff);
    chk("pass", i2.pass, e.ps);
    chk("busy_at_done", i2.busy, 0);
  endtask

  task automatic sweep2(input int md, input bit mid_start);
    mode = md;
    sb.push_back(model(md, 49));
    i2.start = 1'b1;
    tick;
    i2.start = 1'b0;
    chk("busy_after_start", i2.busy, 1);
    finish2(mid_start);
    tick;
    chk("done_one_cycle", i2.done, 0);
  endtask

  initial begin
    int k;
    int dcount;
    bit got;
    exp_t e;
    int ix;
    logic [3:0] ib;

    mode = 0;
    rst2_n = 1'b0;
    rst0_n = 1'b0;
    i2.start = 1'b0;
    i0.start = 1'b0;
    repeat (3) tick;

    // Reset state
    chk("rst_a_out", i2.a_out, 0);
    chk("rst_b_out", i2.b_out, 0);
    chk("rst_busy", i2.busy, 0);
    chk("rst_done", i2.done, 0);
    chk("rst_pass", i2.pass, 0);
    chk("rst_err_cnt", i2.err_cnt, 0);
    chk("rst_fail_valid", i2.fail_valid, 0);
    chk("rst_first_fail", i2.first_fail, 0);
    rst2_n = 1'b1;
    rst0_n = 1'b1;
    tick;

    // SETTLE_CYCLES=0: one cycle per pair, operands walk 0..15
    sb.push_back(model(0, 17));
    for (int q = 0; q < 16; q++) idxq.push_back(q);
    i0.start = 1'b1;
    tick;
    i0.start = 1'b0;
    k = 0;
    ix = idxq.pop_front();
    ib = ix[3:0];
    chk("s0_a_out", i0.a_out, ib[3:2]);
    chk("s0_b_out", i0.b_out, ib[1:0]);
    got = 1'b0;
    while (!got && k < 100) begin
      tick;
      k++;
      if (i0.done === 1'b1) got = 1'b1;
      else if (idxq.size() > 0) begin
        ix = idxq.pop_front();
        ib = ix[3:0];
        chk("s0_a_out", i0.a_out, ib[3:2]);
        chk("s0_b_out", i0.b_out, ib[1:0]);
      end
    end
    e = sb.pop_front();
    chk("s0_done_seen", got, 1);
    chk("s0_latency", k, e.lat);
    chk("s0_pairs_left", idxq.size(), 0);
    chk("s0_pass", i0.pass, e.ps);
    chk("s0_err_cnt", i0.err_cnt, e.err);

    // SETTLE_CYCLES=2 sweeps
    sweep2(0, 1'b0);
    sweep2(1, 1'b0);
    sweep2(2, 1'b1);

    // IDLE holds operands and results
    repeat (4) tick;
    chk("idle_a_hold", i2.a_out, 3);
    chk("idle_b_hold", i2.b_out, 3);
    chk("idle_err_hold", i2.err_cnt, 12);
    chk("idle_ff_hold", i2.first_fail, 1);

    // start held high through DONE restarts on first IDLE cycle
    mode = 0;
    sb.push_back(model(0, 49));
    i2.start = 1'b1;
    tick;
    finish2(1'b0);
    sb.push_back(model(0, 49));
    tick;
    chk("restart_busy", i2.busy, 1);
    chk("restart_pass_clr", i2.pass, 0);
    chk("restart_done_low", i2.done, 0);
    i2.start = 1'b0;
    finish2(1'b0);

    // Reset mid-sweep aborts without a done pulse
    mode = 1;
    i2.start = 1'b1;
    tick;
    i2.start = 1'b0;
    repeat (20) tick;
    chk("pre_reset_err", i2.err_cnt, 2);
    chk("pre_reset_fv", i2.fail_valid, 1);
    rst2_n = 1'b0;
    tick;
    chk("abort_a_out", i2.a_out, 0);
    chk("abort_b_out", i2.b_out, 0);
    chk("abort_err_cnt", i2.err_cnt, 0);
    chk("abort_fail_valid", i2.fail_valid, 0);
    chk("abort_busy", i2.busy, 0);
    chk("abort_done", i2.done, 0);
    rst2_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 60; c++) begin
      tick;
      if (i2.done === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);

    // Reset wins over start in the same cycle
    rst2_n = 1'b0;
    i2.start = 1'b1;
    tick;
    chk("rst_prio_busy", i2.busy, 0);
    rst2_n = 1'b1;
    i2.start = 1'b0;
    tick;
    chk("rst_prio_idle", i2.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
